// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
//
// Purpose:
//   Shares one SRAM-like memory port (req / addr_ok / data_ok handshake)
//   between the instruction-fetch requester and the data (load/store)
//   requester. The arbiter has three jobs:
//     - It picks which requester owns the address phase. Data normally wins.
//       Inst is forced to win after losing STARVE_MAX times in a row.
//     - It holds that choice until the memory accepts the address.
//     - It records the owner of every accepted transaction in a small
//       in-order ID FIFO, so that each bus_data_ok can be steered back to
//       the right requester.
//
// Parameters:
//   MAX_OUT    : maximum accepted-but-unanswered transactions (1..4)
//   STARVE_MAX : consecutive data wins tolerated while inst is waiting
//
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   inst_* / data_* (inputs)    : requester address-phase fields; req is
//                                 held high until the matching addr_ok
//   inst_/data_addr_ok          : address phase accepted (combinational)
//   inst_/data_data_ok          : response for that requester's oldest
//                                 outstanding transaction (combinational)
//   inst_/data_rdata            : read data, broadcast from bus_rdata
//   bus_req/wr/size/wstrb/
//   bus_addr/wdata              : address phase toward memory; the fields
//                                 are driven to 0 when bus_req is low
//   bus_addr_ok, bus_data_ok,
//   bus_rdata                   : memory handshake and in-order responses
// ---------------------------------------------------------------------------
module sram_bus_arbiter #(
  parameter int MAX_OUT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [CW-1:0] C_FULL     = CW'(MAX_OUT);
  localparam logic [CW-1:0] C_EMPTY    = {CW{1'b0}};
  localparam logic [PW-1:0] C_PTR_LAST = PW'(MAX_OUT - 1);
  localparam logic [SW-1:0] C_STARVE   = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_ready;    // low during reset and for one cycle after release
  logic [CW-1:0]      r_count;
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [MAX_OUT-1:0] r_fifo;     // owner ID per slot: 0 = inst, 1 = data
  logic [SW-1:0]      r_starve;

  logic w_gnt_i;
  logic w_gnt_d;
  logic w_accept;
  logic w_pop;
  logic w_head;

  // Advance a FIFO pointer, wrapping at MAX_OUT (which may not be a power of two).
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == C_PTR_LAST) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // Grant selection. A locked requester keeps the port until its address is
  // accepted. The full check is not repeated while locked, because count can
  // only fall during a lock. When idle, data wins unless inst has starved.
  always_comb begin
    w_gnt_i = 1'b0;
    w_gnt_d = 1'b0;
    if (r_ready) begin
      case (r_state)
        ST_IDLE: begin
          if (r_count == C_FULL) begin
            w_gnt_i = 1'b0;
            w_gnt_d = 1'b0;
          end else if ((r_starve == C_STARVE) && inst_req) begin
            w_gnt_i = 1'b1;
          end else if (data_req) begin
            w_gnt_d = 1'b1;
          end else if (inst_req) begin
            w_gnt_i = 1'b1;
          end else begin
            w_gnt_i = 1'b0;
            w_gnt_d = 1'b0;
          end
        end
        ST_LOCK_I: w_gnt_i = 1'b1;
        ST_LOCK_D: w_gnt_d = 1'b1;
        default: begin
          w_gnt_i = 1'b0;
          w_gnt_d = 1'b0;
        end
      endcase
    end else begin
      w_gnt_i = 1'b0;
      w_gnt_d = 1'b0;
    end
  end

  assign bus_req      = w_gnt_i | w_gnt_d;
  assign w_accept     = bus_req & bus_addr_ok;
  assign inst_addr_ok = w_gnt_i & bus_addr_ok;
  assign data_addr_ok = w_gnt_d & bus_addr_ok;

  // A response with nothing outstanding is a stray pulse, e.g. one belonging
  // to a transaction that a reset threw away. It is dropped.
  assign w_pop        = bus_data_ok & (r_count != C_EMPTY);
  assign w_head       = r_fifo[r_rd_ptr];
  assign inst_data_ok = w_pop & ~w_head;
  assign data_data_ok = w_pop &  w_head;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  // Address-phase field mux; fields are forced to zero when there is no grant.
  always_comb begin
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_wstrb = 4'd0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    if (w_gnt_d) begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_wstrb = data_wstrb;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
    end else if (w_gnt_i) begin
      bus_wr    = inst_wr;
      bus_size  = inst_size;
      bus_wstrb = inst_wstrb;
      bus_addr  = inst_addr;
      bus_wdata = inst_wdata;
    end else begin
      bus_wr    = 1'b0;
      bus_size  = 2'd0;
      bus_wstrb = 4'd0;
      bus_addr  = 32'd0;
      bus_wdata = 32'd0;
    end
  end

  // Lock FSM plus the post-reset quiet cycle. An acceptance always returns
  // to IDLE; a grant that is not accepted locks onto its requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      case (r_state)
        ST_IDLE, ST_LOCK_I, ST_LOCK_D: begin
          if (w_accept) begin
            r_state <= ST_IDLE;
          end else if (w_gnt_i) begin
            r_state <= ST_LOCK_I;
          end else if (w_gnt_d) begin
            r_state <= ST_LOCK_D;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-ID FIFO. Push and pop may happen in the same cycle; the count
  // then holds while both pointers move. A pop needs count > 0, so an entry
  // pushed this cycle can never be popped in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fifo   <= {MAX_OUT{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= C_EMPTY;
    end else begin
      if (w_accept) begin
        r_fifo[r_wr_ptr] <= w_gnt_d;
        r_wr_ptr         <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter. It counts data acceptances that happened while inst
  // was waiting, saturates at STARVE_MAX, and clears when inst is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= {SW{1'b0}};
    end else begin
      if (inst_addr_ok) begin
        r_starve <= {SW{1'b0}};
      end else if (data_addr_ok && inst_req && (r_starve != C_STARVE)) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_arbiter
//
// Directed scenarios followed by randomized traffic. Every cycle, all
// outputs are compared against a reference model. The model keeps:
//   - a queue of outstanding owners,
//   - the requester currently holding the port (if any),
//   - a starvation count.
// ---------------------------------------------------------------------------
module tb_sram_bus_arbiter;

  localparam int MAX_OUT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model state: 0 = inst, 1 = data in the queue; lock 0/1/2 = none/inst/data.
  int q[$];
  int m_lock   = 0;
  int m_starve = 0;
  bit m_ready  = 1'b0;
  bit exp_iacc = 1'b0;
  bit exp_dacc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_lock   = 0;
    m_starve = 0;
    m_ready  = 1'b0;
  endtask

  task automatic set_i(input logic [31:0] a);
    inst_wr    = 1'b0;
    inst_size  = 2'd2;
    inst_wstrb = 4'hF;
    inst_addr  = a;
    inst_wdata = 32'd0;
  endtask

  task automatic set_d(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    data_wr    = wr;
    data_size  = 2'd2;
    data_wstrb = 4'hF;
    data_addr  = a;
    data_wdata = wd;
  endtask

  // One cycle. Inputs are driven at the negedge before this call. The task
  // checks every output against the model, advances the model across the
  // posedge, and returns at the next negedge.
  task automatic step();
    int          g;
    bit          pop, head, acc;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;
    #1;
    if (reset || !m_ready)                             g = 0;
    else if (m_lock != 0)                              g = m_lock;
    else if (q.size() == MAX_OUT)                      g = 0;
    else if (m_starve == STARVE_MAX && inst_req === 1'b1) g = 1;
    else if (data_req === 1'b1)                        g = 2;
    else if (inst_req === 1'b1)                        g = 1;
    else                                               g = 0;
    pop  = !reset && (bus_data_ok === 1'b1) && (q.size() > 0);
    head = pop ? (q[0] == 1) : 1'b0;
    acc  = (g != 0) && (bus_addr_ok === 1'b1);
    e_wr = 1'b0; e_size = 2'd0; e_wstrb = 4'd0; e_addr = 32'd0; e_wdata = 32'd0;
    if (g == 1) begin
      e_wr = inst_wr; e_size = inst_size; e_wstrb = inst_wstrb; e_addr = inst_addr; e_wdata = inst_wdata;
    end else if (g == 2) begin
      e_wr = data_wr; e_size = data_size; e_wstrb = data_wstrb; e_addr = data_addr; e_wdata = data_wdata;
    end
    chk("bus_req",      32'(bus_req),      32'(g != 0));
    chk("bus_wr",       32'(bus_wr),       32'(e_wr));
    chk("bus_size",     32'(bus_size),     32'(e_size));
    chk("bus_wstrb",    32'(bus_wstrb),    32'(e_wstrb));
    chk("bus_addr",     bus_addr,          e_addr);
    chk("bus_wdata",    bus_wdata,         e_wdata);
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(acc && g == 1));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(acc && g == 2));
    chk("inst_data_ok", 32'(inst_data_ok), 32'(pop && !head));
    chk("data_data_ok", 32'(data_data_ok), 32'(pop && head));
    chk("count",        32'(dut.r_count),  32'(q.size()));
    chk("starve",       32'(dut.r_starve), 32'(m_starve));
    if (pop) begin
      chk("inst_rdata", inst_rdata, bus_rdata);
      chk("data_rdata", data_rdata, bus_rdata);
    end
    exp_iacc = acc && (g == 1);
    exp_dacc = acc && (g == 2);
    if (reset) begin
      m_reset();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back((g == 2) ? 1 : 0);
        m_lock = 0;
        if (g == 1) m_starve = 0;
        else if (inst_req === 1'b1 && m_starve < STARVE_MAX) m_starve++;
      end else if (g != 0) begin
        m_lock = g;
      end
      m_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b0; data_req = 1'b0;
    set_i(32'd0); set_d(1'b0, 32'd0, 32'd0);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    @(negedge clk);
    step();
    step();

    // Release with both requesting: the first cycle after release must stay quiet.
    reset = 1'b0;
    inst_req = 1'b1; data_req = 1'b1;
    set_i(32'h0000_1000); set_d(1'b0, 32'h1C00_0000, 32'd0);
    bus_addr_ok = 1'b1;
    #1 chk("rel_quiet", 32'(bus_req), 32'd0);
    step();

    // Simultaneous requests: data first, inst next cycle, responses in order.
    #1 chk("t1_data_aok", 32'(data_addr_ok), 32'd1);
    chk("t1_inst_wait", 32'(inst_addr_ok), 32'd0);
    step();
    data_req = 1'b0;
    #1 chk("t1_inst_aok", 32'(inst_addr_ok), 32'd1);
    step();
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
    #1 chk("t1_data_dok", 32'(data_data_ok), 32'd1);
    chk("t1_data_rdata", data_rdata, 32'h1111_1111);
    step();
    bus_rdata = 32'h2222_2222;
    #1 chk("t1_inst_dok", 32'(inst_data_ok), 32'd1);
    chk("t1_inst_rdata", inst_rdata, 32'h2222_2222);
    step();
    // Stray response with an empty FIFO is ignored.
    bus_rdata = 32'h3333_3333;
    #1 chk("stray_inst_dok", 32'(inst_data_ok), 32'd0);
    chk("stray_data_dok", 32'(data_data_ok), 32'd0);
    step();
    bus_data_ok = 1'b0;
    #1 chk("stray_count", 32'(dut.r_count), 32'd0);

    // Lock: data held for three cycles, inst arrives mid-lock and must wait.
    data_req = 1'b1; set_d(1'b1, 32'h1C00_0100, 32'hCAFE_0001);
    step();
    inst_req = 1'b1; set_i(32'h0000_2000);
    for (int c = 0; c < 2; c++) begin
      #1 chk("lock_addr", bus_addr, 32'h1C00_0100);
      chk("lock_no_inst", 32'(inst_addr_ok), 32'd0);
      step();
    end
    bus_addr_ok = 1'b1;
    #1 chk("lock_data_aok", 32'(data_addr_ok), 32'd1);
    chk("lock_addr_acc", bus_addr, 32'h1C00_0100);
    step();
    data_req = 1'b0;
    #1 chk("lock_inst_next", bus_addr, 32'h0000_2000);
    step();
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5555_AAAA;
    step();
    step();
    bus_data_ok = 1'b0;

    // Full FIFO blocks the grant; a response frees a slot for the next cycle.
    inst_req = 1'b1; bus_addr_ok = 1'b1;
    set_i(32'h0000_3000); step();
    set_i(32'h0000_3004); step();
    set_i(32'h0000_3008);
    #1 chk("full_no_req", 32'(bus_req), 32'd0);
    chk("full_count", 32'(dut.r_count), 32'd2);
    step();
    bus_data_ok = 1'b1;
    #1 chk("full_still_blocked", 32'(bus_req), 32'd0);
    step();
    #1 chk("freed_req", 32'(bus_req), 32'd1);
    chk("freed_push_pop", 32'(inst_data_ok), 32'd1);
    step();
    inst_req = 1'b0; bus_data_ok = 1'b0; bus_addr_ok = 1'b0;
    #1 chk("push_pop_count", 32'(dut.r_count), 32'd1);
    bus_data_ok = 1'b1;
    step();
    bus_data_ok = 1'b0;

    // Starvation: four data wins while inst waits, then inst is forced through.
    inst_req = 1'b1; set_i(32'h0000_4000);
    data_req = 1'b1; set_d(1'b1, 32'h1C00_0200, 32'hDEAD_BEEF);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0BAD_F00D;
    for (int c = 0; c < STARVE_MAX; c++) begin
      #1 chk("starve_data_win", 32'(data_addr_ok), 32'd1);
      step();
    end
    #1 chk("starve_sat", 32'(dut.r_starve), 32'(STARVE_MAX));
    chk("starve_inst_win", 32'(inst_addr_ok), 32'd1);
    chk("starve_data_lose", 32'(data_addr_ok), 32'd0);
    step();
    inst_req = 1'b0;
    #1 chk("starve_clear", 32'(dut.r_starve), 32'd0);
    data_req = 1'b0; bus_addr_ok = 1'b0;
    step();
    bus_data_ok = 1'b0;

    // Async reset with two outstanding, asserted between clock edges.
    data_req = 1'b1; inst_req = 1'b1; bus_addr_ok = 1'b1;
    step();
    data_req = 1'b0;
    step();
    bus_data_ok = 1'b1;
    #1 chk("pre_rst_dok", 32'(data_data_ok), 32'd1);
    #1 reset = 1'b1;
    m_reset();
    #1 chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_inst_dok", 32'(inst_data_ok), 32'd0);
    chk("rst_data_dok", 32'(data_data_ok), 32'd0);
    chk("rst_count", 32'(dut.r_count), 32'd0);
    step();
    reset = 1'b0; data_req = 1'b1;
    step();
    #1 chk("post_rst_idle_data", 32'(data_addr_ok), 32'd1);
    step();
    data_req = 1'b0; bus_data_ok = 1'b0; bus_addr_ok = 1'b0;

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (exp_iacc) inst_req = 1'b0;
      if (exp_dacc) data_req = 1'b0;
      if (inst_req !== 1'b1 && ($urandom % 2) == 0) begin
        inst_req = 1'b1; inst_wr = 1'($urandom % 2); inst_size = 2'($urandom_range(0, 2));
        inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (data_req !== 1'b1 && ($urandom % 2) == 0) begin
        data_req = 1'b1; data_wr = 1'($urandom % 2); data_size = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
      bus_addr_ok = 1'($urandom % 2);
      bus_data_ok = 1'(($urandom % 5) < 2);
      bus_rdata   = $urandom;
      if (($urandom % 400) == 0) begin
        reset = 1'b1;
        m_reset();
        step();
        reset = 1'b0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
